// File: rtl/frame_sequencer_pkg.sv
// Shared constants and state encoding for the double-buffered frame sequencer.
package frame_sequencer_pkg;

    localparam int         DEF_PX_WIDTH  = 160;
    localparam int         DEF_PX_HEIGHT = 120;
    localparam int         DEF_ADDR_W    = 16;
    localparam logic [2:0] DEF_BG_CODE   = 3'b000;
    localparam int         DEF_TIMEOUT   = 200000;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_CLEAR   = 3'd1,
        FS_START   = 3'd2,
        FS_DRAW    = 3'd3,
        FS_WAIT_VB = 3'd4,
        FS_SWAP    = 3'd5
    } fs_state_t;

endpackage

// File: rtl/frame_sequencer_vsync_edge.sv
// Brings the asynchronous active-low vsync into the clk domain and flags the start
// of vertical blank as a one-cycle pulse on the synchronised falling edge.
module vsync_edge (
    input  logic clk,
    input  logic clr,
    input  logic vsync,
    output logic vblank_start
);

    // Two synchroniser stages plus one history stage for the edge compare
    logic [2:0] sync_r;

    // Shift vsync through the synchroniser chain
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], vsync};
        end
    end

    // Resetting to 0 means the first idle-high vsync is seen as a rise, never a fall
    assign vblank_start = sync_r[2] & ~sync_r[1];

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: clears the back buffer, starts the renderer, waits for it,
// then swaps front/back banks on the next vertical blank.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int         PX_WIDTH  = DEF_PX_WIDTH,
    parameter int         PX_HEIGHT = DEF_PX_HEIGHT,
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter logic [2:0] BG_CODE   = DEF_BG_CODE,
    parameter int         TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              frame_tick,
    input  logic              vsync,
    input  logic              render_done,
    output logic              render_start,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [2:0]        clr_data,
    output logic              front_sel,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              overrun,
    output logic              render_err
);

    localparam int                NPIX      = PX_WIDTH * PX_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int                TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    fs_state_t         state_r;
    fs_state_t         state_s;
    logic              vblank_start_s;
    logic              consume_s;
    logic              pending_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              clr_we_r;
    logic              render_start_r;
    logic              busy_r;
    logic              front_sel_r;
    logic [15:0]       frame_cnt_r;
    logic              overrun_r;
    logic              render_err_r;

    vsync_edge u_vsync_edge (
        .clk          (clk),
        .clr          (clr),
        .vsync        (vsync),
        .vblank_start (vblank_start_s)
    );

    assign consume_s = (state_r == FS_IDLE) && pending_r;

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            FS_IDLE: begin
                if (pending_r) state_s = FS_CLEAR;
                else           state_s = FS_IDLE;
            end
            FS_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) state_s = FS_START;
                else                         state_s = FS_CLEAR;
            end
            FS_START: state_s = FS_DRAW;
            FS_DRAW: begin
                if (render_done || (to_cnt_r == TO_LAST)) state_s = FS_WAIT_VB;
                else                                      state_s = FS_DRAW;
            end
            FS_WAIT_VB: begin
                if (vblank_start_s) state_s = FS_SWAP;
                else                state_s = FS_WAIT_VB;
            end
            FS_SWAP: state_s = FS_IDLE;
            default: state_s = FS_IDLE;
        endcase
    end

    // State register and per-state outputs, registered from the next state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r        <= FS_IDLE;
            clr_we_r       <= 1'b0;
            render_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            clr_we_r       <= (state_s == FS_CLEAR);
            render_start_r <= (state_s == FS_START);
            busy_r         <= (state_s != FS_IDLE);
        end
    end

    // Clear address, render timeout counter and the sticky timeout flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clr_addr_r   <= '0;
            to_cnt_r     <= '0;
            render_err_r <= 1'b0;
        end else begin
            if (state_r == FS_IDLE) begin
                clr_addr_r <= '0;
            end else if ((state_r == FS_CLEAR) && (clr_addr_r != LAST_ADDR)) begin
                clr_addr_r <= clr_addr_r + ADDR_W'(1);
            end
            if (state_r == FS_START) begin
                to_cnt_r <= '0;
            end else if (state_r == FS_DRAW) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if ((state_r == FS_DRAW) && !render_done && (to_cnt_r == TO_LAST)) begin
                render_err_r <= 1'b1;
            end
        end
    end

    // Bank swap and completed-frame count, updated as SWAP is entered
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            front_sel_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else if (state_s == FS_SWAP) begin
            front_sel_r <= ~front_sel_r;
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    // One-deep tick request; a tick arriving while one is still queued is lost
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else if (frame_tick) begin
            pending_r <= 1'b1;
            if (pending_r && !consume_s) overrun_r <= 1'b1;
        end else if (consume_s) begin
            pending_r <= 1'b0;
        end
    end

    assign render_start = render_start_r;
    assign clr_we       = clr_we_r;
    assign clr_addr     = clr_addr_r;
    assign clr_data     = BG_CODE;
    assign front_sel    = front_sel_r;
    assign busy         = busy_r;
    assign frame_cnt    = frame_cnt_r;
    assign overrun      = overrun_r;
    assign render_err   = render_err_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on a 4x2 pixel memory with a 20-cycle render timeout.
module tb_frame_sequencer;

    localparam int PXW  = 4;
    localparam int PXH  = 2;
    localparam int NPIX = PXW * PXH;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        clr;
    logic        frame_tick;
    logic        vsync;
    logic        render_done;
    logic        render_start;
    logic        clr_we;
    logic [15:0] clr_addr;
    logic [2:0]  clr_data;
    logic        front_sel;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic        render_err;

    always #5 clk = ~clk;

    frame_sequencer #(
        .PX_WIDTH (PXW),
        .PX_HEIGHT(PXH),
        .ADDR_W   (16),
        .BG_CODE  (3'b000),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .frame_tick  (frame_tick),
        .vsync       (vsync),
        .render_done (render_done),
        .render_start(render_start),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr),
        .clr_data    (clr_data),
        .front_sel   (front_sel),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .render_err  (render_err)
    );

    typedef struct {
        logic [15:0] cnt;
        logic        fs;
    } swap_t;

    typedef struct {
        int dly;       // DRAW cycles before render_done; -1 = never
        bit early_vb;  // vsync falls while still drawing
        bit exp_err;   // render_err expected after the frame
    } vec_t;

    swap_t       swap_q[$];
    int          clr_q[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          rs_cnt     = 0;
    logic [15:0] exp_cnt    = 16'd0;
    logic        exp_fs     = 1'b0;
    logic [15:0] prev_cnt   = 16'd0;
    bit          ignore_cnt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Queue the clear writes and the swap result one frame will produce
    task automatic expect_frame();
        swap_t s;
        for (int a = 0; a < NPIX; a++) clr_q.push_back(a);
        exp_cnt = exp_cnt + 16'd1;
        exp_fs  = ~exp_fs;
        s.cnt   = exp_cnt;
        s.fs    = exp_fs;
        swap_q.push_back(s);
    endtask

    // From render_start through the swap back to IDLE (or into the next CLEAR)
    task automatic finish_frame(input int dly, input bit early_vb, input bit tick_in_swap);
        int          lat;
        logic [15:0] cnt0;
        logic        err0;
        cnt0 = frame_cnt;
        lat  = 0;
        while (!render_start && lat < 40) begin
            step();
            lat++;
        end
        check("render_start_seen", render_start, 1);
        step();
        if (early_vb) begin
            vsync = 1'b0;
            repeat (3) step();
            vsync = 1'b1;
            repeat (2) step();
        end
        if (dly >= 0) begin
            repeat (dly - (early_vb ? 5 : 0)) step();
            render_done = 1'b1;
            step();
            render_done = 1'b0;
        end else begin
            err0 = render_err;
            repeat (TO - 1) step();
            check("render_err_pre_timeout", render_err, err0);
            step();
            check("render_err_timeout", render_err, 1);
        end
        step();
        check("no_early_swap", frame_cnt, cnt0);
        check("busy_wait_vb", busy, 1);
        vsync = 1'b0;
        lat   = 0;
        while (frame_cnt == cnt0 && lat < 20) begin
            step();
            lat++;
        end
        check("swap_latency", lat, 3);
        if (tick_in_swap) begin
            expect_frame();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("idle_between_frames", busy, 0);
            step();
            check("clear_after_idle", clr_we, 1);
            vsync = 1'b1;
        end else begin
            vsync = 1'b1;
            step();
            check("idle_after_swap", busy, 0);
        end
    endtask

    // Scoreboard: every clear write must match the next queued address
    always @(negedge clk) begin
        if (!clr) begin
            if (render_start) rs_cnt++;
            if (clr_we) begin
                if (clr_q.size() == 0) begin
                    check("clr_unexpected", clr_we, 0);
                end else begin
                    check("clr_addr", clr_addr, 32'(clr_q.pop_front()));
                    check("clr_data", clr_data, 3'b000);
                end
            end
        end
    end

    // Scoreboard: every frame_cnt change must match the next queued swap
    always @(negedge clk) begin
        swap_t e;
        if (clr || ignore_cnt) begin
            prev_cnt = frame_cnt;
        end else if (frame_cnt != prev_cnt) begin
            if (swap_q.size() == 0) begin
                check("swap_unexpected", frame_cnt, prev_cnt);
            end else begin
                e = swap_q.pop_front();
                check("frame_cnt", frame_cnt, e.cnt);
                check("front_sel", front_sel, e.fs);
            end
            prev_cnt = frame_cnt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   rs0;

        vecs[0] = '{dly: 5,  early_vb: 1'b0, exp_err: 1'b0};
        vecs[1] = '{dly: 19, early_vb: 1'b0, exp_err: 1'b0};
        vecs[2] = '{dly: 0,  early_vb: 1'b0, exp_err: 1'b0};
        vecs[3] = '{dly: 10, early_vb: 1'b1, exp_err: 1'b0};
        vecs[4] = '{dly: -1, early_vb: 1'b0, exp_err: 1'b1};
        vecs[5] = '{dly: 3,  early_vb: 1'b0, exp_err: 1'b1};

        clr         = 1'b1;
        frame_tick  = 1'b0;
        vsync       = 1'b1;
        render_done = 1'b0;
        repeat (3) step();
        check("rst_render_start", render_start, 0);
        check("rst_clr_we", clr_we, 0);
        check("rst_clr_addr", clr_addr, 0);
        check("rst_front_sel", front_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_overrun", overrun, 0);
        check("rst_render_err", render_err, 0);
        clr = 1'b0;
        step();

        // Reset in the middle of a clear abandons it
        for (int a = 0; a < NPIX; a++) clr_q.push_back(a);
        pulse_tick();
        lat = 0;
        while (!(clr_we && clr_addr == 16'd3) && lat < 20) begin
            step();
            lat++;
        end
        check("reach_addr3", clr_addr, 3);
        clr = 1'b1;
        step();
        check("midclr_clr_we", clr_we, 0);
        check("midclr_clr_addr", clr_addr, 0);
        check("midclr_busy", busy, 0);
        check("midclr_front_sel", front_sel, 0);
        check("midclr_render_start", render_start, 0);
        clr_q.delete();
        clr = 1'b0;
        repeat (5) step();
        check("idle_no_tick_busy", busy, 0);
        check("idle_no_tick_clr_we", clr_we, 0);

        // Table of frames: nominal, done boundaries, early vblank, timeout, sticky error
        for (int i = 0; i < 6; i++) begin
            rs0 = rs_cnt;
            expect_frame();
            pulse_tick();
            lat = 1;
            while (!clr_we && lat < 10) begin
                step();
                lat++;
            end
            check("clr_we_latency", lat, 2);
            while (!render_start && lat < 40) begin
                step();
                lat++;
            end
            check("render_start_latency", lat, 2 + NPIX);
            check("clr_we_off_at_start", clr_we, 0);
            finish_frame(vecs[i].dly, vecs[i].early_vb, 1'b0);
            check("vec_render_err", render_err, vecs[i].exp_err);
            check("vec_one_render_start", rs_cnt, rs0 + 1);
            check("vec_clears_done", clr_q.size(), 0);
            check("vec_no_overrun", overrun, 0);
        end

        // Overrun: one queued tick survives, the next is dropped
        expect_frame();
        pulse_tick();
        step();
        expect_frame();
        pulse_tick();
        check("overrun_one_pending", overrun, 0);
        pulse_tick();
        check("overrun_set", overrun, 1);
        finish_frame(4, 1'b0, 1'b0);
        finish_frame(4, 1'b0, 1'b0);
        repeat (10) step();
        check("overrun_two_frames_only", busy, 0);
        check("overrun_frame_cnt", frame_cnt, exp_cnt);
        check("overrun_clears_done", clr_q.size(), 0);

        // Tick during SWAP: one IDLE cycle, then straight into CLEAR
        expect_frame();
        pulse_tick();
        finish_frame(2, 1'b0, 1'b1);
        finish_frame(2, 1'b0, 1'b0);
        check("b2b_frame_cnt", frame_cnt, exp_cnt);

        // Counter wrap from 16'hFFFF
        ignore_cnt = 1'b1;
        force dut.frame_cnt_r = 16'hFFFF;
        step();
        release dut.frame_cnt_r;
        step();
        ignore_cnt = 1'b0;
        exp_cnt = 16'hFFFF;
        expect_frame();
        pulse_tick();
        finish_frame(1, 1'b0, 1'b0);
        check("wrap_frame_cnt", frame_cnt, 0);
        check("wrap_front_sel", front_sel, exp_fs);
        check("final_swaps_done", swap_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
